// File: rtl/ifetch_unit_if.sv
// Fetch-side bus: enable, instruction-memory port, redirect and delivery handshake.
// The fetch unit takes the master modport, and the environment takes the slave modport.
interface ifetch_unit_if #(
   parameter int AW = 9
);
   logic          en;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_data;
   logic          br_valid;
   logic [AW-1:0] br_target;
   logic          ins_valid;
   logic          ins_ready;
   logic [31:0]   ins_data;
   logic [AW-1:0] ins_pc;
   logic [15:0]   fetch_cnt;

   modport master (
      input  en, imem_data, br_valid, br_target, ins_ready,
      output imem_addr, ins_valid, ins_data, ins_pc, fetch_cnt
   );

   modport slave (
      output en, imem_data, br_valid, br_target, ins_ready,
      input  imem_addr, ins_valid, ins_data, ins_pc, fetch_cnt
   );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: PC sequencer feeding a small FIFO of {pc, instruction}.
// A redirect flushes the FIFO and reloads the PC, and it takes priority over push and pop.
module ifetch_unit #(
   parameter int DEPTH = 2,
   parameter int AW    = 9
) (
   input  logic          clka,
   input  logic          rst,
   ifetch_unit_if.master bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] epc_q  [DEPTH];
   logic          push, pop;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      cnt_d   = cnt_q;
      head_d  = head_q;
      tail_d  = tail_q;
      fcnt_d  = fcnt_q;
      push    = 1'b0;
      pop     = 1'b0;

      case (state_q)
         IDLE:    if (bus.en)  state_d = RUN;
         RUN:     if (!bus.en) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (bus.br_valid) begin
         cnt_d  = '0;
         tail_d = head_q;
         pc_d   = bus.br_target;
      end else begin
         pop  = (cnt_q != '0) && bus.ins_ready;
         // A pop frees a slot on the same edge, so a full buffer can still accept a push.
         push = (state_q == RUN) && ((cnt_q < CW'(DEPTH)) || pop);
         if (pop) begin
            head_d = head_q + 1'b1;
            fcnt_d = fcnt_q + 1'b1;
         end
         if (push) begin
            tail_d = tail_q + 1'b1;
            pc_d   = pc_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         pc_q    <= '0;
         cnt_q   <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         cnt_q   <= cnt_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // Entries are cleared on reset so the head reads as zero straight out of reset.
   always_ff @(posedge clka or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_q[i] <= '0;
            epc_q[i]  <= '0;
         end
      end else if (push) begin
         data_q[tail_q] <= bus.imem_data;
         epc_q[tail_q]  <= pc_q;
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.ins_valid = (cnt_q != '0);
   assign bus.ins_data  = data_q[head_q];
   assign bus.ins_pc    = epc_q[head_q];
   assign bus.fetch_cnt = fcnt_q;
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus a randomized run, all compared
// against a queue-based reference model of the fetch buffer.
module tb_ifetch_unit;
   localparam int DEPTH = 2;
   localparam int AW    = 9;

   typedef struct {
      logic [AW-1:0] pc;
      logic [31:0]   d;
   } ent_t;

   logic clka;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   ent_t          mq[$];
   logic [AW-1:0] m_pc;
   logic [15:0]   m_fc;
   bit            m_run;

   ifetch_unit_if #(.AW(AW)) bus ();

   ifetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clka (clka),
      .rst  (rst),
      .bus  (bus.master)
   );

   function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
      return 32'hA000_0000 + 32'(a);
   endfunction

   assign bus.imem_data = mem_word(bus.imem_addr);

   initial clka = 1'b0;
   always #5 clka = ~clka;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_pc  = '0;
      m_fc  = '0;
      m_run = 1'b0;
   endtask

   // One clock edge of the reference model, computed from the current inputs.
   task automatic model_step(input bit en, input bit br, input logic [AW-1:0] tgt, input bit rdy);
      bit pop, push;
      if (br) begin
         mq.delete();
         m_pc = tgt;
      end else begin
         pop  = (mq.size() != 0) && rdy;
         push = m_run && ((mq.size() < DEPTH) || pop);
         if (pop) begin
            void'(mq.pop_front());
            m_fc++;
         end
         if (push) begin
            mq.push_back('{pc: m_pc, d: mem_word(m_pc)});
            m_pc++;
         end
      end
      m_run = en;
   endtask

   task automatic compare_all();
      chk("imem_addr", 32'(bus.imem_addr), 32'(m_pc));
      chk("ins_valid", 32'(bus.ins_valid), 32'(mq.size() != 0));
      if (mq.size() != 0) begin
         chk("ins_data", bus.ins_data, mq[0].d);
         chk("ins_pc", 32'(bus.ins_pc), 32'(mq[0].pc));
      end
      chk("fetch_cnt", 32'(bus.fetch_cnt), 32'(m_fc));
   endtask

   // Called at a falling edge: drive inputs, advance the model, then compare at the next falling edge.
   task automatic cyc(input bit en, input bit br, input logic [AW-1:0] tgt, input bit rdy);
      bus.en        = en;
      bus.br_valid  = br;
      bus.br_target = tgt;
      bus.ins_ready = rdy;
      model_step(en, br, tgt, rdy);
      @(negedge clka);
      compare_all();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_imem_addr"}, 32'(bus.imem_addr), 32'd0);
      chk({tag, "_ins_valid"}, 32'(bus.ins_valid), 32'd0);
      chk({tag, "_ins_data"},  bus.ins_data,       32'd0);
      chk({tag, "_ins_pc"},    32'(bus.ins_pc),    32'd0);
      chk({tag, "_fetch_cnt"}, 32'(bus.fetch_cnt), 32'd0);
   endtask

   // Assert reset between clock edges, check outputs clear at once, release at the next falling edge.
   task automatic mid_reset(input string tag);
      #2;
      rst = 1'b0;
      #1;
      check_reset_outputs(tag);
      model_reset();
      bus.en        = 1'b0;
      bus.br_valid  = 1'b0;
      bus.br_target = '0;
      bus.ins_ready = 1'b0;
      @(negedge clka);
      check_reset_outputs({tag, "_held"});
      rst = 1'b1;
   endtask

   initial begin
      rst           = 1'b0;
      bus.en        = 1'b0;
      bus.br_valid  = 1'b0;
      bus.br_target = '0;
      bus.ins_ready = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("por");
      @(negedge clka);
      @(negedge clka);
      rst = 1'b1;

      // Streaming with a permanently ready consumer: one instruction per cycle after startup.
      for (int i = 0; i < 12; i++) cyc(1'b1, 1'b0, '0, 1'b1);
      chk("stream_pc", 32'(bus.ins_pc), 32'd10);
      chk("stream_cnt", 32'(bus.fetch_cnt), 32'd10);

      // Back-pressure: the buffer fills and the PC stalls at DEPTH.
      mid_reset("rst_a");
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, '0, 1'b0);
      chk("bp_addr", 32'(bus.imem_addr), 32'd2);
      chk("bp_head", 32'(bus.ins_pc), 32'd0);
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("full_pp_head", 32'(bus.ins_pc), 32'd1);
      chk("full_pp_addr", 32'(bus.imem_addr), 32'd3);
      cyc(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0, 1'b1);

      // Redirect while the buffer holds pc 5 and 6.
      mid_reset("rst_b");
      for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, '0, 1'b1);
      chk("pre_br_head", 32'(bus.ins_pc), 32'd5);
      cyc(1'b1, 1'b0, '0, 1'b0);
      cyc(1'b1, 1'b1, AW'(100), 1'b1);
      chk("br_valid_clr", 32'(bus.ins_valid), 32'd0);
      chk("br_addr", 32'(bus.imem_addr), 32'd100);
      chk("br_cnt", 32'(bus.fetch_cnt), 32'd5);
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("br_first", 32'(bus.ins_pc), 32'd100);
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("br_second", 32'(bus.ins_pc), 32'd101);

      // PC wrap through the top of the address space.
      cyc(1'b1, 1'b1, AW'(510), 1'b1);
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("wrap_510", 32'(bus.ins_pc), 32'd510);
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("wrap_511", 32'(bus.ins_pc), 32'd511);
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("wrap_0", 32'(bus.ins_pc), 32'd0);
      cyc(1'b1, 1'b0, '0, 1'b1);
      chk("wrap_1", 32'(bus.ins_pc), 32'd1);

      // Pause: buffered entries drain, PC holds.
      cyc(1'b1, 1'b0, '0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, '0, 1'b1);
      chk("pause_valid", 32'(bus.ins_valid), 32'd0);

      // Randomized traffic.
      for (int i = 0; i < 400; i++) begin
         bit            en, br, rdy;
         logic [AW-1:0] tgt;
         en  = ($urandom_range(0, 9) != 0);
         br  = ($urandom_range(0, 15) == 0);
         tgt = ($urandom_range(0, 3) == 0) ? AW'(509 + $urandom_range(0, 2)) : AW'($urandom_range(0, 511));
         rdy = ($urandom_range(0, 2) != 0);
         cyc(en, br, tgt, rdy);
      end

      // Reset with a full buffer, then restart from address 0.
      for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, '0, 1'b0);
      chk("pre_rst_full", 32'(bus.ins_valid), 32'd1);
      mid_reset("rst_c");
      for (int i = 0; i < 2; i++) cyc(1'b1, 1'b0, '0, 1'b1);
      chk("restart_pc", 32'(bus.ins_pc), 32'd0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, '0, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
